outpkt_framer: RTL and testbench

Packet framer that sits directly upstream of the high-speed output limit FIFO. It takes a packet request (type, id, length) and a first-word-fall-through stream of 16-bit payload words from the result buffer. It writes header, payload and optional checksum words into the FIFO, one word per cycle, and never writes while the FIFO reports full.

---
 rtl/outpkt_framer.sv | 170 +++++++++++++++++
 tb/tb_outpkt_framer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outpkt_framer.sv
// rtl/outpkt_framer.sv - header/payload/checksum packet framer feeding the output limit FIFO
// Optional trailing checksum word enabled by defining OUTPKT_CHECKSUM_EN.
module outpkt_framer #(
    parameter logic [7:0] VERSION = 8'h02,
    parameter int         WIDTH   = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             pkt_start,
    input  logic [3:0]       pkt_type,
    input  logic [15:0]      pkt_id,
    input  logic [7:0]       pkt_len,
    output logic             pkt_ready,
    output logic             pkt_done,
    input  logic [WIDTH-1:0] din,
    input  logic             din_empty,
    output logic             din_rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             wr_en,
    input  logic             full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_DATA
`ifdef OUTPKT_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] type_q, type_d;
    logic [15:0] id_q, id_d;
    logic [7:0] len_q, len_d;
`ifdef OUTPKT_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
`ifdef OUTPKT_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            id_q    <= id_d;
            len_q   <= len_d;
`ifdef OUTPKT_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Everything only advances on a transfer, so stalls freeze state, counter and accumulator.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        id_d    = id_q;
        len_d   = len_q;
`ifdef OUTPKT_CHECKSUM_EN
        acc_d   = acc_q;
        if (wr_en) begin
            acc_d = acc_q + dout;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (pkt_start && pkt_ready) begin
                    type_d  = pkt_type;
                    id_d    = pkt_id;
                    len_d   = pkt_len;
                    cnt_d   = pkt_len;
`ifdef OUTPKT_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = S_HDR0;
                end
            end
            S_HDR0: if (wr_en) state_d = S_HDR1;
            S_HDR1: if (wr_en) state_d = S_HDR2;
            S_HDR2: begin
                if (wr_en) begin
                    if (len_q != 8'd0) begin
                        state_d = S_DATA;
                    end else begin
`ifdef OUTPKT_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            S_DATA: begin
                if (wr_en) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
`ifdef OUTPKT_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef OUTPKT_CHECKSUM_EN
            S_CSUM: if (wr_en) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // full reaches wr_en through logic only, so a full FIFO is never written.
    always_comb begin
        pkt_ready = 1'b0;
        pkt_done  = 1'b0;
        din_rd_en = 1'b0;
        wr_en     = 1'b0;
        dout      = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: pkt_ready = 1'b1;
                S_HDR0: begin
                    dout  = {VERSION, 4'h0, type_q};
                    wr_en = !full;
                end
                S_HDR1: begin
                    dout  = id_q;
                    wr_en = !full;
                end
                S_HDR2: begin
                    dout  = {8'h00, len_q};
                    wr_en = !full;
`ifndef OUTPKT_CHECKSUM_EN
                    pkt_done = !full && (len_q == 8'd0);
`endif
                end
                S_DATA: begin
                    dout      = din;
                    wr_en     = !full && !din_empty;
                    din_rd_en = !full && !din_empty;
`ifndef OUTPKT_CHECKSUM_EN
                    pkt_done  = !full && !din_empty && (cnt_q == 8'd1);
`endif
                end
`ifdef OUTPKT_CHECKSUM_EN
                S_CSUM: begin
                    dout     = ~acc_q;
                    wr_en    = !full;
                    pkt_done = !full;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_outpkt_framer.sv
// tb/tb_outpkt_framer.sv - randomized self-checking bench for outpkt_framer
// Expected words come from a packet-level model; build with or without OUTPKT_CHECKSUM_EN.
module tb_outpkt_framer;

    logic        CLK = 1'b0;
    logic        rst;
    logic        pkt_start;
    logic [3:0]  pkt_type;
    logic [15:0] pkt_id;
    logic [7:0]  pkt_len;
    logic        pkt_ready;
    logic        pkt_done;
    logic [15:0] din;
    logic        din_empty;
    logic        din_rd_en;
    logic [15:0] dout;
    logic        wr_en;
    logic        full;

    always #5 CLK = ~CLK;

    outpkt_framer #(.VERSION(8'h02), .WIDTH(16)) dut (
        .CLK(CLK), .rst(rst), .pkt_start(pkt_start), .pkt_type(pkt_type),
        .pkt_id(pkt_id), .pkt_len(pkt_len), .pkt_ready(pkt_ready),
        .pkt_done(pkt_done), .din(din), .din_empty(din_empty),
        .din_rd_en(din_rd_en), .dout(dout), .wr_en(wr_en), .full(full)
    );

`ifdef OUTPKT_CHECKSUM_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 3;
`endif

    typedef struct {
        logic [3:0]  t;
        logic [15:0] id;
        logic [7:0]  len;
    } req_t;

    req_t        req_q[$];
    logic [15:0] exp_q[$];
    bit          data_q[$];
    bit          done_q[$];
    logic [15:0] pay_q[$];
    logic [15:0] fixed_pay[$];

    int vectors = 0;
    int miscompares = 0;

    // A packet is a list of words; the checksum is the complement of their plain 16-bit sum.
    function automatic void add_packet(input logic [3:0] t, input logic [15:0] id, input logic [7:0] len);
        req_t        r;
        logic [15:0] w;
        logic [15:0] sum;
        r.t = t; r.id = id; r.len = len;
        req_q.push_back(r);
        sum = 16'h0000;
        w = {8'h02, 4'h0, t};
        exp_q.push_back(w); data_q.push_back(0); done_q.push_back(0); sum = sum + w;
        exp_q.push_back(id); data_q.push_back(0); done_q.push_back(0); sum = sum + id;
        w = {8'h00, len};
        exp_q.push_back(w); data_q.push_back(0); done_q.push_back(0); sum = sum + w;
        for (int i = 0; i < int'(len); i++) begin
            if (fixed_pay.size() > 0) w = fixed_pay.pop_front();
            else w = 16'($urandom);
            pay_q.push_back(w);
            exp_q.push_back(w); data_q.push_back(1); done_q.push_back(0); sum = sum + w;
        end
`ifdef OUTPKT_CHECKSUM_EN
        exp_q.push_back(~sum); data_q.push_back(0); done_q.push_back(1);
`else
        done_q[done_q.size()-1] = 1;
`endif
    endfunction

    // Drives queued requests and stall patterns, checking every cycle against the model.
    // mode 0: no stalls, 1: random full/din_empty, 2: full 3 cycles at HDR1 and empty 2 cycles mid-DATA.
    task automatic run_traffic(input int mode, input int abort_after, output int span,
                               output int lat, output logic [15:0] last_word);
        int   wc = 0, fst = 0, est = 0, first = -1, last = -1, acc = -1;
        bit   finished = 0;
        logic exp_rd;
        last_word = 16'h0000;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            if (req_q.size() > 0) begin
                pkt_start = 1'b1;
                pkt_type  = req_q[0].t;
                pkt_id    = req_q[0].id;
                pkt_len   = req_q[0].len;
            end else begin
                pkt_start = 1'b0;
                pkt_type  = 4'($urandom);
                pkt_id    = 16'($urandom);
                pkt_len   = 8'($urandom);
            end
            case (mode)
                1: begin
                    full      = ($urandom_range(0, 99) < 30);
                    din_empty = ($urandom_range(0, 99) < 30);
                end
                2: begin
                    full      = (wc == 1 && fst < 3);
                    din_empty = (wc == 4 && est < 2);
                    if (full) fst++;
                    if (din_empty) est++;
                end
                default: begin
                    full      = 1'b0;
                    din_empty = 1'b0;
                end
            endcase
            din = (pay_q.size() > 0) ? pay_q[0] : 16'($urandom);
            #1;
            vectors++;
            if (wr_en === 1'b1 && full === 1'b1) begin
                miscompares++;
                $display("FAIL wr_en_while_full: wr_en=%b full=%b at cycle %0d", wr_en, full, cyc);
            end
            exp_rd = (wr_en === 1'b1) && (exp_q.size() > 0) && data_q[0];
            vectors++;
            if (din_rd_en !== exp_rd) begin
                miscompares++;
                $display("FAIL din_rd_en: got %b expected %b at cycle %0d", din_rd_en, exp_rd, cyc);
            end
            if (wr_en === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_write: dout=%h with no word expected at cycle %0d", dout, cyc);
                end else begin
                    if (dout !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL dout_word%0d: got %h expected %h", wc, dout, exp_q[0]);
                    end
                    vectors++;
                    if (pkt_done !== done_q[0]) begin
                        miscompares++;
                        $display("FAIL pkt_done_word%0d: got %b expected %b", wc, pkt_done, done_q[0]);
                    end
                    last_word = dout;
                    void'(exp_q.pop_front());
                    void'(data_q.pop_front());
                    void'(done_q.pop_front());
                    wc++;
                    if (first < 0) first = cyc;
                    if (pkt_done === 1'b1) last = cyc;
                end
            end else begin
                vectors++;
                if (pkt_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pkt_done_idle: got %b expected 0 at cycle %0d", pkt_done, cyc);
                end
            end
            if (din_rd_en === 1'b1 && pay_q.size() > 0) void'(pay_q.pop_front());
            if (pkt_ready === 1'b1 && pkt_start && req_q.size() > 0) begin
                if (acc < 0) acc = cyc;
                void'(req_q.pop_front());
            end
            if (abort_after > 0 && wc == abort_after) begin
                finished = 1;
                break;
            end
            if (exp_q.size() == 0 && req_q.size() == 0) begin
                finished = 1;
                break;
            end
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL timeout: %0d words still expected, 0 required", exp_q.size());
        end
        span = last - first + 1;
        lat  = first - acc;
    endtask

    task automatic test_reset();
        rst = 1'b1; pkt_start = 1'b1; full = 1'b0; din_empty = 1'b0; din = 16'h1234;
        pkt_type = 4'h1; pkt_id = 16'h0001; pkt_len = 8'd1;
        repeat (2) @(negedge CLK);
        #1;
        vectors++;
        if ({pkt_ready, wr_en, din_rd_en, pkt_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: ready/wr/rd/done=%b expected 0000", {pkt_ready, wr_en, din_rd_en, pkt_done});
        end
        @(negedge CLK);
        rst = 1'b0; pkt_start = 1'b0;
        #1;
        vectors++;
        if (pkt_ready !== 1'b1 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: pkt_ready=%b wr_en=%b expected 1 0", pkt_ready, wr_en);
        end
    endtask

    task automatic test_basic();
        int span, lat; logic [15:0] lw;
        fixed_pay = '{16'h1111, 16'h2222};
        add_packet(4'h1, 16'h0005, 8'd2);
        run_traffic(0, 0, span, lat, lw);
        vectors++;
        if (span !== 2 + EXTRA || lat !== 1) begin
            miscompares++;
            $display("FAIL basic_timing: span=%0d lat=%0d expected %0d 1", span, lat, 2 + EXTRA);
        end
        vectors++;
`ifdef OUTPKT_CHECKSUM_EN
        if (lw !== 16'hCAC4) begin
            miscompares++;
            $display("FAIL basic_csum: got %h expected CAC4", lw);
        end
`else
        if (lw !== 16'h2222) begin
            miscompares++;
            $display("FAIL basic_last: got %h expected 2222", lw);
        end
`endif
    endtask

    task automatic test_wrap();
        int span, lat; logic [15:0] lw;
        fixed_pay = '{16'h0003};
        add_packet(4'h0, 16'hFFFF, 8'd1);
        run_traffic(0, 0, span, lat, lw);
        vectors++;
`ifdef OUTPKT_CHECKSUM_EN
        if (lw !== 16'hFDFC) begin
            miscompares++;
            $display("FAIL wrap_csum: got %h expected FDFC", lw);
        end
`else
        if (lw !== 16'h0003) begin
            miscompares++;
            $display("FAIL wrap_last: got %h expected 0003", lw);
        end
`endif
    endtask

    task automatic test_backpressure();
        int span, lat; logic [15:0] lw;
        fixed_pay = '{16'h1111, 16'h2222};
        add_packet(4'h1, 16'h0005, 8'd2);
        run_traffic(2, 0, span, lat, lw);
        vectors++;
        if (span !== 2 + EXTRA + 5) begin
            miscompares++;
            $display("FAIL backpressure_span: got %0d expected %0d", span, 2 + EXTRA + 5);
        end
    endtask

    task automatic test_len0();
        int span, lat; logic [15:0] lw;
        add_packet(4'h3, 16'h0010, 8'd0);
        run_traffic(0, 0, span, lat, lw);
        vectors++;
`ifdef OUTPKT_CHECKSUM_EN
        if (lw !== 16'hFDEC || span !== 4) begin
            miscompares++;
            $display("FAIL len0: last=%h span=%0d expected FDEC 4", lw, span);
        end
`else
        if (lw !== 16'h0000 || span !== 3) begin
            miscompares++;
            $display("FAIL len0: last=%h span=%0d expected 0000 3", lw, span);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int span, lat; logic [15:0] lw;
        add_packet(4'($urandom), 16'($urandom), 8'd8);
        run_traffic(0, 4, span, lat, lw);
        @(negedge CLK);
        rst = 1'b1; full = 1'b0; din_empty = 1'b0;
        #1;
        vectors++;
        if (wr_en !== 1'b0 || din_rd_en !== 1'b0 || pkt_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: wr_en=%b rd=%b ready=%b expected 0 0 0", wr_en, din_rd_en, pkt_ready);
        end
        exp_q.delete(); data_q.delete(); done_q.delete(); pay_q.delete(); req_q.delete();
        @(negedge CLK);
        rst = 1'b0;
        #1;
        vectors++;
        if (pkt_ready !== 1'b1 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_release: ready=%b wr_en=%b expected 1 0", pkt_ready, wr_en);
        end
        add_packet(4'h6, 16'hBEEF, 8'd3);
        run_traffic(0, 0, span, lat, lw);
    endtask

    task automatic test_back_to_back();
        int span, lat; logic [15:0] lw;
        int l1, l2;
        l1 = $urandom_range(1, 10);
        l2 = $urandom_range(0, 10);
        add_packet(4'($urandom), 16'($urandom), 8'(l1));
        add_packet(4'($urandom), 16'($urandom), 8'(l2));
        run_traffic(0, 0, span, lat, lw);
        vectors++;
        if (span !== (l1 + EXTRA) + (l2 + EXTRA) + 1) begin
            miscompares++;
            $display("FAIL back_to_back_span: got %0d expected %0d", span, (l1 + EXTRA) + (l2 + EXTRA) + 1);
        end
    endtask

    task automatic test_random();
        int span, lat; logic [15:0] lw;
        for (int p = 0; p < 20; p++) begin
            add_packet(4'($urandom), 16'($urandom),
                       ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 24)));
            run_traffic(1, 0, span, lat, lw);
        end
        for (int p = 0; p < 3; p++) add_packet(4'($urandom), 16'($urandom), 8'($urandom_range(0, 12)));
        run_traffic(1, 0, span, lat, lw);
        add_packet(4'hF, 16'($urandom), 8'd255);
        run_traffic(1, 0, span, lat, lw);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
